// File: rtl/uart_brg_gen_if.sv
// SFR-side bus of the baud generator: SPBRG/SPBRGH write strobes, write data and readback.
interface uart_brg_gen_if;
  logic       brg_lo_wr_en;
  logic       brg_hi_wr_en;
  logic [7:0] brg_in;
  logic [7:0] brg_lo_out;
  logic [7:0] brg_hi_out;

  modport master (
    output brg_lo_wr_en,
    output brg_hi_wr_en,
    output brg_in,
    input  brg_lo_out,
    input  brg_hi_out
  );

  modport slave (
    input  brg_lo_wr_en,
    input  brg_hi_wr_en,
    input  brg_in,
    output brg_lo_out,
    output brg_hi_out
  );
endinterface

// File: rtl/uart_brg_gen.sv
// UART baud-rate generator: SPBRGH:SPBRG divisor, SYNC/BRGH/BRG16 prescale, tx and rx strobes.
// Auto-baud measurement is built only when UART_BRG_AUTOBAUD_EN is defined.
module uart_brg_gen #(
  parameter int BRG_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_brg_gen_if.slave bus,
  input  logic          en,
  input  logic          sync,
  input  logic          brgh,
  input  logic          brg16,
  output logic          tx_shift_en,
  output logic          rx_sample_en,
  output logic          rx_os16,
  input  logic          rx_pin,
  input  logic          abd_start,
  output logic          abd_busy,
  output logic          abd_done,
  output logic          abd_ovf
);

  localparam logic HI_EN = (BRG_WIDTH == 16);

  logic [15:0] divisor;
  logic [15:0] div_next;
  logic [15:0] div_cnt;
  logic [15:0] abd_div;
  logic [5:0]  pre_cnt;
  logic [5:0]  pre_last;
  logic        base_tick;
  logic        pre_wrap;
  logic        rx_phase;
  logic        wr_any;
  logic        busy;
  logic        abd_load;

  always_comb begin
    pre_last = 6'd63;
    if (sync)
      pre_last = 6'd3;
    else if (brg16 && brgh)
      pre_last = 6'd3;
    else if (brg16 || brgh)
      pre_last = 6'd15;
  end

  assign base_tick = (div_cnt == divisor);
  assign pre_wrap  = (pre_cnt >= pre_last);
  // At P=64 the 16x strobe falls on every fourth base tick; at P=16 and P=4 on every one.
  assign rx_phase  = (pre_last == 6'd63) ? (pre_cnt[1:0] == 2'b11) : 1'b1;
  assign wr_any    = bus.brg_lo_wr_en | (bus.brg_hi_wr_en & HI_EN);

  // A register write always wins over an auto-baud load in the same cycle.
  always_comb begin
    div_next = divisor;
    if (abd_load)
      div_next = abd_div;
    if (bus.brg_lo_wr_en)
      div_next[7:0] = bus.brg_in;
    if (bus.brg_hi_wr_en && HI_EN)
      div_next[15:8] = bus.brg_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      divisor <= '0;
    else
      divisor <= div_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      pre_cnt <= '0;
    end else if (!en || wr_any || abd_load) begin
      div_cnt <= '0;
      pre_cnt <= '0;
    end else if (!busy) begin
      if (base_tick) begin
        div_cnt <= '0;
        pre_cnt <= pre_wrap ? 6'd0 : pre_cnt + 6'd1;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  assign tx_shift_en    = rst & en & ~busy & base_tick & pre_wrap;
  assign rx_sample_en   = rst & en & ~busy & base_tick & rx_phase;
  assign rx_os16        = rst & (pre_last != 6'd3);
  assign bus.brg_lo_out = divisor[7:0];
  assign bus.brg_hi_out = divisor[15:8];

`ifdef UART_BRG_AUTOBAUD_EN

  typedef enum logic [1:0] {
    ABD_IDLE,
    ABD_WAIT,
    ABD_MEASURE
  } abd_state_t;

  localparam logic [16:0] MEAS_MAX = 17'd1 << BRG_WIDTH;

  abd_state_t  state;
  abd_state_t  state_next;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic        rx_fall;
  logic [8:0]  sub_cnt;
  logic [8:0]  sub_last;
  logic        sub_tick;
  logic [16:0] meas_cnt;
  logic [16:0] meas_inc;
  logic [2:0]  edge_cnt;
  logic        ovf_set;
  logic        done_q;
  logic        ovf_q;

  assign rx_fall  = rx_prev & ~rx_s2;
  // One measurement unit is 8*P cycles, so eight bit times of 0x55 yield N+1 units.
  assign sub_last = {pre_last, 3'b111};
  assign sub_tick = (sub_cnt >= sub_last);
  assign meas_inc = meas_cnt + {16'd0, sub_tick};
  assign abd_div  = (meas_inc == 17'd0) ? 16'd0 : 16'(meas_inc - 17'd1);
  assign busy     = (state != ABD_IDLE);

  always_comb begin
    state_next = state;
    abd_load   = 1'b0;
    ovf_set    = 1'b0;
    case (state)
      ABD_IDLE: begin
        if (abd_start)
          state_next = ABD_WAIT;
      end
      ABD_WAIT: begin
        if (rx_fall)
          state_next = ABD_MEASURE;
      end
      ABD_MEASURE: begin
        if (meas_inc > MEAS_MAX) begin
          ovf_set    = 1'b1;
          state_next = ABD_IDLE;
        end else if (rx_fall && edge_cnt == 3'd4) begin
          abd_load   = 1'b1;
          state_next = ABD_IDLE;
        end
      end
      default: state_next = ABD_IDLE;
    endcase
    if (wr_any) begin
      state_next = ABD_IDLE;
      abd_load   = 1'b0;
      ovf_set    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ABD_IDLE;
      rx_s1    <= 1'b0;
      rx_s2    <= 1'b0;
      rx_prev  <= 1'b0;
      sub_cnt  <= '0;
      meas_cnt <= '0;
      edge_cnt <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state   <= state_next;
      rx_s1   <= rx_pin;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      done_q  <= abd_load;
      if (state == ABD_IDLE && abd_start && !wr_any)
        ovf_q <= 1'b0;
      else if (ovf_set)
        ovf_q <= 1'b1;
      // The falling edge that leaves WAIT is the start bit, so it is edge number one.
      if (state == ABD_WAIT) begin
        sub_cnt  <= '0;
        meas_cnt <= '0;
        edge_cnt <= 3'd1;
      end else if (state == ABD_MEASURE) begin
        sub_cnt  <= sub_tick ? 9'd0 : sub_cnt + 9'd1;
        meas_cnt <= meas_inc;
        if (rx_fall)
          edge_cnt <= edge_cnt + 3'd1;
      end
    end
  end

  assign abd_busy = busy;
  assign abd_done = done_q;
  assign abd_ovf  = ovf_q;

`else

  logic unused_abd;

  assign busy       = 1'b0;
  assign abd_load   = 1'b0;
  assign abd_div    = 16'd0;
  assign abd_busy   = 1'b0;
  assign abd_done   = 1'b0;
  assign abd_ovf    = 1'b0;
  assign unused_abd = ^{rx_pin, abd_start};

`endif

endmodule

// File: tb/tb_uart_brg_gen.sv
// Directed bench for uart_brg_gen: a 16-bit and an 8-bit instance share mode controls and rx_pin.
module tb_uart_brg_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, sync, brgh, brg16, rx_pin, abd_start16, abd_start8;
  logic tx16, rx16, os16_16, busy16, done16, ovf16;
  logic tx8, rx8, os16_8, busy8, done8, ovf8;

  int checks = 0;
  int errors = 0;
  int done16_seen = 0;
  int done8_seen = 0;
  int tx_cnt, tx_first, tx_second, rx_cnt, rx_first, rx_second;

  uart_brg_gen_if bus16();
  uart_brg_gen_if bus8();

  uart_brg_gen #(.BRG_WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .bus(bus16), .en(en), .sync(sync), .brgh(brgh), .brg16(brg16),
    .tx_shift_en(tx16), .rx_sample_en(rx16), .rx_os16(os16_16), .rx_pin(rx_pin),
    .abd_start(abd_start16), .abd_busy(busy16), .abd_done(done16), .abd_ovf(ovf16)
  );

  uart_brg_gen #(.BRG_WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .bus(bus8), .en(en), .sync(sync), .brgh(brgh), .brg16(brg16),
    .tx_shift_en(tx8), .rx_sample_en(rx8), .rx_os16(os16_8), .rx_pin(rx_pin),
    .abd_start(abd_start8), .abd_busy(busy8), .abd_done(done8), .abd_ovf(ovf8)
  );

  always @(negedge clk) begin
    if (done16) done16_seen++;
    if (done8) done8_seen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en_v, input logic sync_v, input logic brgh_v, input logic brg16_v);
    @(posedge clk); #1;
    en    = en_v;
    sync  = sync_v;
    brgh  = brgh_v;
    brg16 = brg16_v;
  endtask

  // Returns one cycle after the write edge, i.e. inside cycle 0 of the restarted count.
  task automatic brg_write(input bit narrow, input logic lo, input logic hi, input logic [7:0] data);
    @(posedge clk); #1;
    if (narrow) begin
      bus8.brg_lo_wr_en = lo; bus8.brg_hi_wr_en = hi; bus8.brg_in = data;
    end else begin
      bus16.brg_lo_wr_en = lo; bus16.brg_hi_wr_en = hi; bus16.brg_in = data;
    end
    @(posedge clk); #1;
    bus8.brg_lo_wr_en = 1'b0; bus8.brg_hi_wr_en = 1'b0;
    bus16.brg_lo_wr_en = 1'b0; bus16.brg_hi_wr_en = 1'b0;
  endtask

  task automatic pulse_start(input bit narrow);
    @(posedge clk); #1;
    if (narrow) abd_start8 = 1'b1; else abd_start16 = 1'b1;
    @(posedge clk); #1;
    abd_start8  = 1'b0;
    abd_start16 = 1'b0;
  endtask

  // Sample ncyc negedges; index 0 is the current cycle. Records count and first two positions.
  task automatic profile(input bit narrow, input int ncyc);
    logic t, r;
    tx_cnt = 0; tx_first = -1; tx_second = -1;
    rx_cnt = 0; rx_first = -1; rx_second = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      t = narrow ? tx8 : tx16;
      r = narrow ? rx8 : rx16;
      if (t) begin
        if (tx_cnt == 0) tx_first = i; else if (tx_cnt == 1) tx_second = i;
        tx_cnt++;
      end
      if (r) begin
        if (rx_cnt == 0) rx_first = i; else if (rx_cnt == 1) rx_second = i;
        rx_cnt++;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int bit_cyc, input int nbits);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      rx_pin = frame[b];
      repeat (bit_cyc) @(posedge clk);
      #1;
    end
    rx_pin = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; sync = 1'b0; brgh = 1'b0; brg16 = 1'b0; rx_pin = 1'b1;
    abd_start16 = 1'b0; abd_start8 = 1'b0;
    bus16.brg_lo_wr_en = 1'b0; bus16.brg_hi_wr_en = 1'b0; bus16.brg_in = 8'h00;
    bus8.brg_lo_wr_en = 1'b0; bus8.brg_hi_wr_en = 1'b0; bus8.brg_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tx", tx16, 0);
    checkOutput("reset_rx", rx16, 0);
    checkOutput("reset_os16", os16_16, 0);
    checkOutput("reset_lo", bus16.brg_lo_out, 0);
    checkOutput("reset_busy", busy16, 0);

    // N=0, P=64
    @(posedge clk); #1;
    rst = 1'b1;
    profile(0, 128);
    checkOutput("p64_os16", os16_16, 1);
    checkOutput("p64_rx_first", rx_first, 3);
    checkOutput("p64_rx_second", rx_second, 7);
    checkOutput("p64_rx_count", rx_cnt, 32);
    checkOutput("p64_tx_first", tx_first, 63);
    checkOutput("p64_tx_second", tx_second, 127);

    // N=300, P=4 via brg16+brgh
    applyStimulus(1, 0, 1, 1);
    brg_write(0, 1, 0, 8'h2C);
    brg_write(0, 0, 1, 8'h01);
    checkOutput("n300_lo", bus16.brg_lo_out, 8'h2C);
    checkOutput("n300_hi", bus16.brg_hi_out, 8'h01);
    checkOutput("n300_os16", os16_16, 0);
    profile(0, 2410);
    checkOutput("n300_tx_first", tx_first, 1203);
    checkOutput("n300_tx_second", tx_second, 2407);
    checkOutput("n300_rx_first", rx_first, 300);

    // Both byte enables together, then N=1 at P=64, then mid-count mode changes
    applyStimulus(1, 0, 0, 0);
    brg_write(0, 1, 1, 8'h07);
    checkOutput("both_lo", bus16.brg_lo_out, 8'h07);
    checkOutput("both_hi", bus16.brg_hi_out, 8'h07);
    brg_write(0, 0, 1, 8'h00);
    brg_write(0, 1, 0, 8'h01);
    profile(0, 260);
    checkOutput("n1_tx_first", tx_first, 127);
    checkOutput("n1_tx_second", tx_second, 255);
    checkOutput("n1_tx_count", tx_cnt, 2);
    applyStimulus(1, 0, 1, 0);
    profile(0, 64);
    checkOutput("brgh_tx_first", tx_first, 27);
    checkOutput("brgh_tx_second", tx_second, 59);
    checkOutput("brgh_tx_count", tx_cnt, 2);
    applyStimulus(1, 1, 1, 0);
    profile(0, 16);
    checkOutput("sync_tx_first", tx_first, 3);
    checkOutput("sync_tx_second", tx_second, 11);
    checkOutput("sync_rx_first", rx_first, 1);
    checkOutput("sync_os16", os16_16, 0);

    // 8-bit instance: hi byte ignored, P=64, N=3
    applyStimulus(1, 0, 0, 0);
    brg_write(1, 0, 1, 8'hFF);
    brg_write(1, 1, 0, 8'h03);
    checkOutput("w8_hi", bus8.brg_hi_out, 0);
    checkOutput("w8_lo", bus8.brg_lo_out, 3);
    profile(1, 520);
    checkOutput("w8_tx_first", tx_first, 255);
    checkOutput("w8_tx_second", tx_second, 511);
    repeat (37) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_tx8", tx8, 0);
    checkOutput("rst_rx8", rx8, 0);
    checkOutput("rst_os16_8", os16_8, 0);
    checkOutput("rst_lo8", bus8.brg_lo_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    profile(1, 130);
    checkOutput("rel_tx_first", tx_first, 63);
    checkOutput("rel_rx_first", rx_first, 3);

    // en=0 holds everything; re-enable restarts from 0 (N=0, P=4)
    applyStimulus(0, 1, 0, 0);
    profile(0, 20);
    checkOutput("dis_tx_count", tx_cnt, 0);
    checkOutput("dis_rx_count", rx_cnt, 0);
    applyStimulus(1, 1, 0, 0);
    profile(0, 12);
    checkOutput("ena_tx_first", tx_first, 3);
    checkOutput("ena_tx_second", tx_second, 7);

`ifdef UART_BRG_AUTOBAUD_EN
    // Auto-baud on the 16-bit instance, P=16, 416 cycles per bit
    applyStimulus(1, 0, 0, 1);
    pulse_start(0);
    checkOutput("abd_busy_on", busy16, 1);
    profile(0, 40);
    checkOutput("abd_hold_tx", tx_cnt, 0);
    checkOutput("abd_hold_rx", rx_cnt, 0);
    send_frame(8'h55, 416, 10);
    checkOutput("abd_done_count", done16_seen, 1);
    checkOutput("abd_busy_off", busy16, 0);
    checkOutput("abd_ovf_clear", ovf16, 0);
    checkOutput("abd_lo", bus16.brg_lo_out, 25);
    checkOutput("abd_hi", bus16.brg_hi_out, 0);
    profile(0, 900);
    checkOutput("abd_tx_period", tx_second - tx_first, 416);

    // Overflow on the 8-bit instance, 8192 cycles per bit
    brg_write(1, 1, 0, 8'h03);
    pulse_start(1);
    send_frame(8'h55, 8192, 5);
    checkOutput("ovf_flag", ovf8, 1);
    checkOutput("ovf_busy", busy8, 0);
    checkOutput("ovf_lo", bus8.brg_lo_out, 3);
    checkOutput("ovf_no_done", done8_seen, 0);
    pulse_start(1);
    checkOutput("ovf_cleared", ovf8, 0);
    checkOutput("restart_busy", busy8, 1);
    brg_write(1, 1, 0, 8'h09);
    checkOutput("abort_busy", busy8, 0);
    checkOutput("abort_lo", bus8.brg_lo_out, 9);
`else
    // Without auto-baud the start pulse and rx_pin have no effect
    applyStimulus(1, 0, 0, 1);
    pulse_start(0);
    rx_pin = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_pin = 1'b1;
    checkOutput("noabd_busy", busy16, 0);
    checkOutput("noabd_ovf", ovf16, 0);
    checkOutput("noabd_done", done16_seen, 0);
    profile(0, 40);
    checkOutput("noabd_rx_count", rx_cnt, 40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_brg_gen.md
Name: uart_brg_gen

Overview:
Parametrised successor to the 8-bit SPBRG baud generator. It holds a BRG_WIDTH-bit divisor (SPBRGH:SPBRG) and generates the UART bit-rate strobe (tx_shift_en) and the 16x receive oversample strobe (rx_sample_en). It adds a 16-bit divisor, a BRG16 mode, an enable, and optional auto-baud measurement. It sits between the UART SFR decode and the uart_tx / uart_rx shifters.

Parameters:
BRG_WIDTH, 16, divisor width; legal values 8 or 16.

Ports:
clk  in  1  system clock (Fosc)
rst  in  1  asynchronous reset, active-low (asserted when 0)
en  in  1  SPEN; 0 holds counters at 0 and forces both strobes to 0
sync  in  1  synchronous mode
brgh  in  1  high-speed select
brg16  in  1  16-bit/fine prescale select
brg_lo_wr_en  in  1  write SPBRG
brg_hi_wr_en  in  1  write SPBRGH
brg_in  in  8  write data
brg_lo_out  out  8  SPBRG readback
brg_hi_out  out  8  SPBRGH readback; 0 when BRG_WIDTH=8
tx_shift_en  out  1  one-cycle strobe, once per bit period
rx_sample_en  out  1  one-cycle oversample strobe
rx_os16  out  1  1 = rx_sample_en is 16x bit rate; 0 = 4x
rx_pin  in  1  raw RX line (auto-baud only)
abd_start  in  1  start auto-baud (pulse)
abd_busy  out  1  auto-baud in progress
abd_done  out  1  one-cycle pulse, measurement loaded
abd_ovf  out  1  sticky overflow flag, cleared by abd_start

Behaviour:
- Prescale P: sync=1 -> 4; else brg16=1 and brgh=1 -> 4; exactly one of brg16/brgh set -> 16; both 0 -> 64. Bit period = P*(N+1) cycles, where N is the divisor.
- rx_os16 = (P != 4).
- Reset: divisor, div_cnt, pre_cnt, the FSM and all flags go to 0; every output is 0.
- div_cnt counts 0..N. base_tick = (div_cnt == N); div_cnt wraps to 0 on base_tick.
- pre_cnt (6 bits) increments on base_tick and wraps to 0 when pre_cnt >= P-1. The >= compare keeps mid-count mode changes bounded.
- tx_shift_en = en & base_tick & (pre_cnt >= P-1). Combinational from registered state.
- rx_sample_en: for P >= 16, asserts when en & base_tick & (pre_cnt mod (P/16)) == P/16-1. For P = 4, asserts on every base_tick.
- Timing: counting from cycle 0 after reset release or a divisor write, the first tx_shift_en is in cycle P*(N+1)-1. The first rx_sample_en is in cycle (P/16)*(N+1)-1 (P >= 16).
- A divisor write updates the selected byte at the clock edge and clears div_cnt and pre_cnt on the same edge.
- Both byte enables in the same cycle write both bytes with brg_in.
- BRG_WIDTH=8: brg_hi_wr_en is ignored.
- Changing sync, brgh or brg16 does not clear the counters.
- Deasserting en clears the counters on the next edge.

Optional Feature:
Macro: UART_BRG_AUTOBAUD_EN

With the macro defined:
- rx_pin passes through a 2-flop synchroniser.
- FSM states: IDLE -> (abd_start) WAIT -> (synchronised falling edge) MEASURE -> (5th falling edge counted from the start bit) IDLE.
- MEASURE increments meas_cnt once every 8*P cycles. For a 0x55 character this gives meas_cnt = N+1 at the 5th edge.
- On the 5th edge: divisor <= meas_cnt-1 (0 if meas_cnt is 0), counters cleared, abd_done pulses for 1 cycle.
- If meas_cnt would exceed 2^BRG_WIDTH: abd_ovf set, return to IDLE, divisor unchanged, no abd_done.
- abd_busy = 1 in WAIT and MEASURE. While busy, both strobes are 0 and the baud counters are held.
- A divisor write during busy takes effect and aborts to IDLE.
- abd_start while busy is ignored.

Without the macro: abd_busy, abd_done and abd_ovf are tied to 0; abd_start and rx_pin are ignored.

Test Plan:
1. N=0, sync=0 brgh=0 brg16=0, en=1 -> rx_sample_en in cycles 3, 7, 11, ...; tx_shift_en in cycles 63, 127; rx_os16=1.
2. Write lo=0x2C, hi=0x01 (N=300), brg16=1 brgh=1 -> readback 0x2C/0x01; rx_os16=0; tx_shift_en every 1204 cycles, first at cycle 1203.
3. N=1, brgh=0 -> tx period 128. Set brgh=1 mid-count -> subsequent tx period 32, no lost or extra pulses beyond one wrap. sync=1 -> period 8.
4. BRG_WIDTH=8: write hi=0xFF then lo=0x03 -> brg_hi_out=0, tx period 256. Assert rst low mid-count -> outputs 0 immediately; counting restarts from 0 on release.
5. UART_BRG_AUTOBAUD_EN, brg16=1 brgh=0 (P=16), abd_start, drive 0x55 at 416 cycles/bit -> abd_done pulse, divisor=25, then tx period 416.
6. UART_BRG_AUTOBAUD_EN, BRG_WIDTH=8, P=16, 0x55 at 8192 cycles/bit -> abd_ovf=1, divisor unchanged, abd_busy=0.
